vc_test_rand_delay_multi_source: RTL and testbench

Multi-channel test source for val/rdy benches. Each of p_num_chans independent lanes plays its own message list and inserts per-message delays before asserting val. Delay mode is selectable at run time: random, fixed or zero. Used to drive multi-port DUTs, such as the DecPipe lanes, under controlled and reproducible backpressure and timing.

---
 rtl/vc_test_src_pkg.sv | 32 +++
 rtl/vc_test_rand_delay_multi_source_if.sv | 24 ++
 rtl/vc_test_rand_delay_lane.sv | 95 +++++++++
 rtl/vc_test_rand_delay_multi_source.sv | 55 +++++
 tb/tb_vc_test_rand_delay_multi_source.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_test_src_pkg.sv
// Shared encodings and helpers for the multi-lane random-delay test source.
package vc_test_src_pkg;

  typedef enum logic [1:0] {
    VC_SRC_MODE_RAND  = 2'd0,
    VC_SRC_MODE_FIXED = 2'd1,
    VC_SRC_MODE_ZERO  = 2'd2,
    VC_SRC_MODE_RSVD  = 2'd3
  } src_mode_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } src_state_e;

  localparam logic [31:0] VC_SRC_LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] VC_SRC_SEED_MIX  = 32'h9E37_79B9;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? VC_SRC_LFSR_TAPS : 32'h0);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int c);
    logic [31:0] s;
    s = base ^ (32'(c) * VC_SRC_SEED_MIX);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/vc_test_rand_delay_multi_source_if.sv
// Per-lane val/rdy/msg bundle plus delay controls and status for the test source.
interface vc_test_rand_delay_multi_source_if #(
  parameter int p_msg_nbits = 64,
  parameter int p_num_chans = 4
);
  logic [31:0]                             max_delay;
  logic [1:0]                              mode;
  logic [p_num_chans-1:0]                  val;
  logic [p_num_chans-1:0]                  rdy;
  logic [p_num_chans-1:0][p_msg_nbits-1:0] msg;
  logic [p_num_chans-1:0]                  done;
  logic                                    all_done;
  logic [p_num_chans-1:0][31:0]            sent_count;

  modport master (
    input  max_delay, mode, rdy,
    output val, msg, done, all_done, sent_count
  );

  modport slave (
    output max_delay, mode, rdy,
    input  val, msg, done, all_done, sent_count
  );
endinterface

// File: rtl/vc_test_rand_delay_lane.sv
// One source lane: delay draw, INIT/DELAY/SEND/DONE sequencing, LFSR and counters.
module vc_test_rand_delay_lane
  import vc_test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 64,
  parameter int          p_num_msgs  = 1024,
  parameter logic [31:0] p_seed      = 32'h1,
  localparam int         AW          = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [31:0]            max_delay,
  input  logic [AW:0]            num_msgs,
  input  logic [p_msg_nbits-1:0] data,
  input  logic                   rdy,
  output logic [AW-1:0]          idx,
  output logic                   val,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done,
  output logic [31:0]            sent_count
);

  src_state_e    state, state_nxt;
  logic [AW-1:0] idx_nxt;
  logic [31:0]   dly_cnt, dly_nxt, lfsr, lfsr_nxt, sent_nxt, draw;
  logic          take;

  // The delay is derived from the current LFSR value; the LFSR only steps when taken.
  always_comb begin
    unique case (mode)
      VC_SRC_MODE_RAND:  draw = 32'({1'b0, lfsr} % ({1'b0, max_delay} + 33'd1));
      VC_SRC_MODE_FIXED: draw = max_delay;
      default:           draw = 32'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dly_nxt   = dly_cnt;
    sent_nxt  = sent_count;
    lfsr_nxt  = lfsr;
    take      = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (num_msgs == '0) state_nxt = ST_DONE;
        else                take      = 1'b1;
      end
      ST_DELAY: begin
        dly_nxt = dly_cnt - 32'd1;
        if (dly_cnt == 32'd1) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (rdy) begin
          sent_nxt = sent_count + 32'd1;
          idx_nxt  = idx + AW'(1);
          if (({1'b0, idx} + (AW+1)'(1)) == num_msgs) state_nxt = ST_DONE;
          else                                        take      = 1'b1;
        end
      end
      default: ;
    endcase
    if (take) begin
      lfsr_nxt = lfsr_step(lfsr);
      if (draw == 32'd0) begin
        state_nxt = ST_SEND;
      end else begin
        state_nxt = ST_DELAY;
        dly_nxt   = draw;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      idx        <= '0;
      dly_cnt    <= 32'd0;
      lfsr       <= p_seed;
      sent_count <= 32'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      dly_cnt    <= dly_nxt;
      lfsr       <= lfsr_nxt;
      sent_count <= sent_nxt;
    end
  end

  assign val  = (state == ST_SEND);
  assign done = (state == ST_DONE);
  assign msg  = val ? data : '0;

endmodule

// File: rtl/vc_test_rand_delay_multi_source.sv
// Multi-lane val/rdy test source: per-lane message stores feeding independent delay lanes.
module vc_test_rand_delay_multi_source
  import vc_test_src_pkg::*;
#(
  parameter int          p_msg_nbits = 64,
  parameter int          p_num_msgs  = 1024,
  parameter int          p_num_chans = 4,
  parameter logic [31:0] p_seed      = 32'hB7C9_1A3D
) (
  input logic                               clk,
  input logic                               reset,
  vc_test_rand_delay_multi_source_if.master bus
);

  localparam int AW = (p_num_msgs > 1)  ? $clog2(p_num_msgs)  : 1;
  localparam int CW = (p_num_chans > 1) ? $clog2(p_num_chans) : 1;

  // Storage survives reset; it is filled only through the tasks below.
  logic [p_msg_nbits-1:0] mem      [p_num_chans][p_num_msgs];
  logic [AW:0]            num_msgs [p_num_chans];

  task automatic load_msg(input int c, input int i, input logic [p_msg_nbits-1:0] value);
    mem[CW'(c)][AW'(i)] = value;
  endtask

  task automatic set_num_msgs(input int c, input int n);
    num_msgs[CW'(c)] = (AW+1)'(n);
  endtask

  for (genvar c = 0; c < p_num_chans; c++) begin : g_lane
    logic [AW-1:0] idx;

    vc_test_rand_delay_lane #(
      .p_msg_nbits (p_msg_nbits),
      .p_num_msgs  (p_num_msgs),
      .p_seed      (lane_seed(p_seed, c))
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .mode       (bus.mode),
      .max_delay  (bus.max_delay),
      .num_msgs   (num_msgs[c]),
      .data       (mem[c][idx]),
      .rdy        (bus.rdy[c]),
      .idx        (idx),
      .val        (bus.val[c]),
      .msg        (bus.msg[c]),
      .done       (bus.done[c]),
      .sent_count (bus.sent_count[c])
    );
  end

  assign bus.all_done = &bus.done;

endmodule

// File: tb/tb_vc_test_rand_delay_multi_source.sv
// Randomized bench for the multi-lane test source against a per-message timing model.
module tb_vc_test_rand_delay_multi_source;

  localparam int          C     = 4;
  localparam int          W     = 64;
  localparam int          NM    = 32;
  localparam logic [31:0] SEED  = 32'hB7C9_1A3D;
  localparam int          NEVER = 1 << 30;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vc_test_rand_delay_multi_source_if #(.p_msg_nbits(W), .p_num_chans(C)) bus ();

  vc_test_rand_delay_multi_source #(
    .p_msg_nbits(W), .p_num_msgs(NM), .p_num_chans(C), .p_seed(SEED)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: message k of lane c is valid from edge m_vat[c]; lane is done from edge m_dat[c].
  logic [W-1:0] m_mem [C][NM];
  int unsigned  m_d   [C][NM];
  int           m_n[C], m_k[C], m_vat[C], m_dat[C], m_sent[C];
  int           ed;
  logic [C-1:0]         exp_val, exp_done;
  logic [C-1:0][W-1:0]  exp_msg;
  logic [C-1:0][31:0]   exp_sent;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] s;
    s = SEED ^ (32'(c) * 32'h9E37_79B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic compute_exp();
    for (int c = 0; c < C; c++) begin
      exp_done[c] = (ed >= m_dat[c]);
      exp_val[c]  = !exp_done[c] && (ed >= m_vat[c]);
      exp_msg[c]  = exp_val[c] ? m_mem[c][m_k[c]] : '0;
      exp_sent[c] = 32'(m_sent[c]);
    end
  endtask

  task automatic model_start(input logic [1:0] md, input logic [31:0] maxd);
    for (int c = 0; c < C; c++) begin
      logic [31:0] s;
      s = seed_of(c);
      for (int k = 0; k < m_n[c]; k++) begin
        if (md == 2'd0)      m_d[c][k] = 32'(64'(s) % (64'(maxd) + 64'd1));
        else if (md == 2'd1) m_d[c][k] = maxd;
        else                 m_d[c][k] = 0;
        s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
      end
      m_k[c] = 0;
      m_sent[c] = 0;
      if (m_n[c] == 0) begin m_dat[c] = 1;     m_vat[c] = NEVER; end
      else             begin m_dat[c] = NEVER; m_vat[c] = 1 + int'(m_d[c][0]); end
    end
    ed = 0;
    compute_exp();
  endtask

  task automatic step(input logic [C-1:0] r);
    bus.rdy = r;
    @(posedge clk); #1;
    ed++;
    for (int c = 0; c < C; c++) begin
      if (m_k[c] < m_n[c] && ed - 1 < m_dat[c] && ed - 1 >= m_vat[c] && r[c]) begin
        m_k[c]++;
        m_sent[c]++;
        if (m_k[c] == m_n[c]) m_dat[c] = ed;
        else                  m_vat[c] = ed + int'(m_d[c][m_k[c]]);
      end
    end
    compute_exp();
  endtask

  task automatic put_msg(input int c, input int i, input logic [W-1:0] v);
    m_mem[c][i] = v;
    dut.load_msg(c, i, v);
  endtask

  task automatic load_lane(input int c, input int n);
    m_n[c] = n;
    dut.set_num_msgs(c, n);
    for (int i = 0; i < n; i++) put_msg(c, i, {$urandom, $urandom});
  endtask

  task automatic restart(input logic [1:0] md, input logic [31:0] maxd);
    reset = 1'b0;
    bus.rdy = '0;
    bus.mode = md;
    bus.max_delay = maxd;
    @(posedge clk); #1;
    model_start(md, maxd);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.rdy = '0; bus.mode = 2'd2; bus.max_delay = 32'd0;
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.val !== '0 || bus.done !== '0 || bus.all_done !== 1'b0 || bus.msg !== '0 || bus.sent_count !== '0) begin
      n_bad++;
      $display("FAIL reset: val=%b done=%b all=%b sent=%h, all required 0", bus.val, bus.done, bus.all_done, bus.sent_count);
    end
  endtask

  task automatic test_zero_mode();
    for (int c = 0; c < C; c++) load_lane(c, 3);
    put_msg(0, 0, 64'h11); put_msg(0, 1, 64'h22); put_msg(0, 2, 64'h33);
    restart(2'd2, 32'd0);
    for (int i = 0; i < 7; i++) begin
      step('1);
      n_cmp++;
      if (bus.val !== exp_val || bus.done !== exp_done || bus.msg !== exp_msg || bus.sent_count !== exp_sent || bus.all_done !== &exp_done) begin
        n_bad++;
        $display("FAIL zero_mode e%0d: val=%b/%b done=%b/%b msg0=%h/%h sent=%h/%h", ed, bus.val, exp_val, bus.done, exp_done, bus.msg[0], exp_msg[0], bus.sent_count, exp_sent);
      end
    end
    n_cmp++;
    if (bus.sent_count[0] !== 32'd3) begin
      n_bad++;
      $display("FAIL zero_mode_count: sent_count[0]=%0d required 3", bus.sent_count[0]);
    end
  endtask

  task automatic test_fixed();
    int first_val = -1, done_edge = -1;
    for (int c = 0; c < C; c++) load_lane(c, 2);
    restart(2'd1, 32'd3);
    for (int i = 0; i < 12; i++) begin
      step('1);
      if (bus.val[0] && first_val < 0) first_val = ed;
      if (bus.done[0] && done_edge < 0) done_edge = ed;
      n_cmp++;
      if (bus.val !== exp_val || bus.done !== exp_done || bus.msg !== exp_msg || bus.sent_count !== exp_sent || bus.all_done !== &exp_done) begin
        n_bad++;
        $display("FAIL fixed e%0d: val=%b/%b done=%b/%b sent=%h/%h", ed, bus.val, exp_val, bus.done, exp_done, bus.sent_count, exp_sent);
      end
    end
    n_cmp++;
    if (first_val !== 4 || done_edge !== 9) begin
      n_bad++;
      $display("FAIL fixed_timing: first val edge %0d done edge %0d, required 4 and 9", first_val, done_edge);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < C; c++) load_lane(c, 4);
    put_msg(0, 0, 64'h11); put_msg(0, 1, 64'h22); put_msg(0, 2, 64'h33); put_msg(0, 3, 64'h44);
    restart(2'd2, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step((i >= 2 && i < 7) ? '0 : '1);
      n_cmp++;
      if (bus.val !== exp_val || bus.done !== exp_done || bus.msg !== exp_msg || bus.sent_count !== exp_sent) begin
        n_bad++;
        $display("FAIL backpressure e%0d: val=%b/%b msg0=%h/%h sent=%h/%h", ed, bus.val, exp_val, bus.msg[0], exp_msg[0], bus.sent_count, exp_sent);
      end
      if (i >= 2 && i < 7) begin
        n_cmp++;
        if (bus.msg[0] !== 64'h22 || bus.sent_count[0] !== 32'd1) begin
          n_bad++;
          $display("FAIL stall_hold e%0d: msg0=%h sent0=%0d, required 22 and 1", ed, bus.msg[0], bus.sent_count[0]);
        end
      end
    end
  endtask

  task automatic test_random_rdy(input logic [31:0] maxd);
    for (int c = 0; c < C; c++) load_lane(c, NM);
    restart(2'd0, maxd);
    for (int i = 0; i < 3000 && !(&exp_done); i++) begin
      step(C'($urandom));
      n_cmp++;
      if (bus.val !== exp_val || bus.done !== exp_done || bus.msg !== exp_msg || bus.sent_count !== exp_sent || bus.all_done !== &exp_done) begin
        n_bad++;
        $display("FAIL random_rdy max%0d e%0d: val=%b/%b done=%b/%b sent=%h/%h", maxd, ed, bus.val, exp_val, bus.done, exp_done, bus.sent_count, exp_sent);
      end
    end
    n_cmp++;
    if (bus.all_done !== 1'b1) begin
      n_bad++;
      $display("FAIL random_rdy_end max%0d: all_done=%b required 1 within budget", maxd, bus.all_done);
    end
  endtask

  task automatic test_repeatable();
    logic [C-1:0] qa[$], qb[$];
    int lane_diff = 0;
    for (int c = 0; c < C; c++) load_lane(c, NM);
    for (int run = 0; run < 2; run++) begin
      restart(2'd0, 32'd7);
      for (int i = 0; i < NM * 9 + 4; i++) begin
        step('1);
        if (run == 0) qa.push_back(bus.val); else qb.push_back(bus.val);
        n_cmp++;
        if (bus.val !== exp_val || bus.msg !== exp_msg || bus.sent_count !== exp_sent) begin
          n_bad++;
          $display("FAIL repeat run%0d e%0d: val=%b/%b sent=%h/%h", run, ed, bus.val, exp_val, bus.sent_count, exp_sent);
        end
      end
    end
    for (int i = 0; i < qa.size(); i++) begin
      if (qa[i][0] != qa[i][1]) lane_diff++;
      n_cmp++;
      if (qb[i] !== qa[i]) begin
        n_bad++;
        $display("FAIL repeat_trace e%0d: second run val=%b, first run %b", i + 1, qb[i], qa[i]);
      end
    end
    n_cmp++;
    if (lane_diff == 0) begin
      n_bad++;
      $display("FAIL lane_seeds: lane0 and lane1 val traces identical, required to differ");
    end
  endtask

  task automatic test_empty_lane();
    int all_edge = -1;
    logic saw_val2 = 1'b0;
    load_lane(0, 4); load_lane(1, 4); load_lane(2, 0); load_lane(3, 6);
    restart(2'd1, 32'd2);
    for (int i = 0; i < 30; i++) begin
      step('1);
      saw_val2 |= bus.val[2];
      if (bus.all_done && all_edge < 0) all_edge = ed;
      if (ed == 1) begin
        n_cmp++;
        if (bus.done[2] !== 1'b1) begin
          n_bad++;
          $display("FAIL empty_done: done[2]=%b at edge 1, required 1", bus.done[2]);
        end
      end
      n_cmp++;
      if (bus.val !== exp_val || bus.done !== exp_done || bus.all_done !== &exp_done || bus.sent_count !== exp_sent) begin
        n_bad++;
        $display("FAIL empty_lane e%0d: val=%b/%b done=%b/%b all=%b/%b", ed, bus.val, exp_val, bus.done, exp_done, bus.all_done, &exp_done);
      end
    end
    n_cmp++;
    if (saw_val2 !== 1'b0 || all_edge !== m_dat[3]) begin
      n_bad++;
      $display("FAIL empty_all_done: val2 seen=%b all_done edge %0d, required 0 and %0d", saw_val2, all_edge, m_dat[3]);
    end
  endtask

  task automatic test_midstream_reset();
    for (int c = 0; c < C; c++) load_lane(c, 4);
    restart(2'd0, 32'd3);
    for (int i = 0; i < 100 && m_sent[0] < 2; i++) begin
      step('1);
      n_cmp++;
      if (bus.val !== exp_val || bus.msg !== exp_msg || bus.sent_count !== exp_sent) begin
        n_bad++;
        $display("FAIL pre_reset e%0d: val=%b/%b sent=%h/%h", ed, bus.val, exp_val, bus.sent_count, exp_sent);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.val !== '0 || bus.done !== '0 || bus.sent_count !== '0 || bus.msg !== '0) begin
      n_bad++;
      $display("FAIL async_reset: val=%b done=%b sent=%h, all required 0 before any edge", bus.val, bus.done, bus.sent_count);
    end
    restart(2'd0, 32'd3);
    for (int i = 0; i < 40; i++) begin
      step('1);
      n_cmp++;
      if (bus.val !== exp_val || bus.done !== exp_done || bus.msg !== exp_msg || bus.sent_count !== exp_sent) begin
        n_bad++;
        $display("FAIL replay e%0d: val=%b/%b done=%b/%b sent=%h/%h", ed, bus.val, exp_val, bus.done, exp_done, bus.sent_count, exp_sent);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_mode();
    test_fixed();
    test_backpressure();
    test_random_rdy(32'd0);
    test_random_rdy(32'd7);
    test_repeatable();
    test_empty_lane();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
